inference_sequencer: RTL and testbench

Controls one inference run of the bin-ratio SNN and sits downstream of the spiking layer.
- Kicks the spike generator by pulsing pre_processing_done.
- Counts timestep-completion pulses and issues get_winner after NUM_STEPS steps.
- Latches winner_id and presents it to the host over a valid/ack handshake.

---
 rtl/snn_ctrl_pkg.sv | 16 +
 rtl/step_counter.sv | 38 +++
 rtl/inference_sequencer.sv | 142 ++++++++++++++
 tb/tb_inference_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_ctrl_pkg.sv
// rtl/snn_ctrl_pkg.sv - shared state encoding and id constants for the SNN run controller
package snn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    KICK = 3'd1,
    RUN  = 3'd2,
    REQ  = 3'd3,
    WAIT = 3'd4,
    HOLD = 3'd5
  } seq_state_t;

  localparam int ID_W = 5;
  localparam logic [ID_W-1:0] TIMEOUT_ID = '1;

endpackage

// File: rtl/step_counter.sv
// rtl/step_counter.sv - saturating up-counter with clear; flags when the next value reaches MAX
module step_counter #(
  parameter int           W   = 10,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max_next
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Looking at the next value lets the owner react on the same edge the count lands.
  assign at_max_next = (count_d == MAX);
  assign count       = count_q;

endmodule

// File: rtl/inference_sequencer.sv
// rtl/inference_sequencer.sv - kicks, counts timesteps and collects the winner of one SNN run
// Optional WAIT watchdog: define INFERENCE_SEQUENCER_TIMEOUT_EN.
module inference_sequencer #(
  parameter int NUM_STEPS   = 1023,
  parameter int STEP_W      = 10,
  parameter int ID_W        = snn_ctrl_pkg::ID_W,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              pre_processing_done,
  input  logic              current_step_finished,
  input  logic              spike_done,
  output logic              get_winner,
  input  logic [ID_W-1:0]   winner_id,
  input  logic              infer_ready,
  output logic [ID_W-1:0]   result_id,
  output logic              result_valid,
  input  logic              result_ack,
  output logic              busy,
  output logic [STEP_W-1:0] step_count,
  output logic              error
);

  import snn_ctrl_pkg::*;

  seq_state_t       state_d, state_q;
  logic [ID_W-1:0]  result_id_d, result_id_q;
  logic             result_valid_d, result_valid_q;
  logic             busy_d, busy_q;
  logic             steps_full_next;

  step_counter #(
    .W   (STEP_W),
    .MAX (STEP_W'(NUM_STEPS))
  ) u_step_counter (
    .clk         (clk),
    .rst         (rst),
    .clr         (state_q == KICK),
    .inc         ((state_q == RUN) && current_step_finished),
    .count       (step_count),
    .at_max_next (steps_full_next)
  );

`ifdef INFERENCE_SEQUENCER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic            error_d, error_q;
  logic            wd_expire;
  logic [WD_W-1:0] wd_count_unused;

  step_counter #(
    .W   (WD_W),
    .MAX (WD_W'(TIMEOUT_CYC))
  ) u_watchdog (
    .clk         (clk),
    .rst         (rst),
    .clr         (state_q != WAIT),
    .inc         (state_q == WAIT),
    .count       (wd_count_unused),
    .at_max_next (wd_expire)
  );
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_d        = state_q;
    result_id_d    = result_id_q;
    result_valid_d = result_valid_q;
`ifdef INFERENCE_SEQUENCER_TIMEOUT_EN
    error_d        = error_q;
`endif
    case (state_q)
      IDLE: if (start) state_d = KICK;
      KICK: state_d = RUN;
      // Saturated count keeps steps_full_next high, so a late spike_done still qualifies.
      RUN:  if (steps_full_next && spike_done) state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (infer_ready) begin
          result_id_d    = winner_id;
          result_valid_d = 1'b1;
          state_d        = HOLD;
        end
`ifdef INFERENCE_SEQUENCER_TIMEOUT_EN
        else if (wd_expire) begin
          result_id_d    = '1;
          result_valid_d = 1'b1;
          error_d        = 1'b1;
          state_d        = HOLD;
        end
`endif
      end
      HOLD: begin
        if (result_ack) begin
          result_valid_d = 1'b0;
`ifdef INFERENCE_SEQUENCER_TIMEOUT_EN
          error_d        = 1'b0;
`endif
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      result_id_q    <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef INFERENCE_SEQUENCER_TIMEOUT_EN
      error_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      result_id_q    <= result_id_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
`ifdef INFERENCE_SEQUENCER_TIMEOUT_EN
      error_q        <= error_d;
`endif
    end
  end

  assign pre_processing_done = (state_q == KICK);
  assign get_winner          = (state_q == REQ);
  assign result_id           = result_id_q;
  assign result_valid        = result_valid_q;
  assign busy                = busy_q;
`ifdef INFERENCE_SEQUENCER_TIMEOUT_EN
  assign error               = error_q;
`else
  assign error               = 1'b0;
`endif

endmodule

// File: tb/tb_inference_sequencer.sv
// tb/tb_inference_sequencer.sv - scoreboard bench for inference_sequencer (NUM_STEPS=4, TIMEOUT_CYC=8)
module tb_inference_sequencer;

  localparam int ID_W   = 5;
  localparam int STEP_W = 10;
  localparam int NSTEP  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              csf = 1'b0;
  logic              spike_done = 1'b0;
  logic              infer_ready = 1'b0;
  logic              result_ack = 1'b0;
  logic [ID_W-1:0]   winner_id = '0;
  logic              ppd;
  logic              get_winner;
  logic [ID_W-1:0]   result_id;
  logic              result_valid;
  logic              busy;
  logic [STEP_W-1:0] step_count;
  logic              error;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  logic [ID_W-1:0] exp_q[$];

  inference_sequencer #(
    .NUM_STEPS   (NSTEP),
    .STEP_W      (STEP_W),
    .ID_W        (ID_W),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .pre_processing_done   (ppd),
    .current_step_finished (csf),
    .spike_done            (spike_done),
    .get_winner            (get_winner),
    .winner_id             (winner_id),
    .infer_ready           (infer_ready),
    .result_id             (result_id),
    .result_valid          (result_valid),
    .result_ack            (result_ack),
    .busy                  (busy),
    .step_count            (step_count),
    .error                 (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic run_steps(input logic sd);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("kick_pulse", 32'(ppd), 1);
    check("busy_rise", 32'(busy), 1);
    cyc();
    check("kick_once", 32'(ppd), 0);
    check("step_clear", 32'(step_count), 0);
    for (int i = 1; i <= NSTEP; i++) begin
      csf        = 1'b1;
      spike_done = sd;
      cyc();
      csf = 1'b0;
      check("step_count", 32'(step_count), 32'(i));
      check("get_winner", 32'(get_winner), (i == NSTEP && sd) ? 1 : 0);
    end
  endtask

  task automatic give_result(input logic [ID_W-1:0] id);
    winner_id   = id;
    infer_ready = 1'b1;
    exp_q.push_back(id);
    cyc();
    infer_ready = 1'b0;
  endtask

  task automatic expect_result(input int budget);
    for (int k = 0; k < budget && !result_valid; k++) cyc();
    if (!result_valid) check("result_valid_wait", 32'(result_valid), 1);
    else if (exp_q.size() == 0) check("sb_depth", 32'(exp_q.size()), 1);
    else check("result_id", 32'(result_id), 32'(exp_q.pop_front()));
  endtask

  task automatic ack_result();
    result_ack = 1'b1;
    cyc();
    result_ack = 1'b0;
    check("valid_drop", 32'(result_valid), 0);
    check("error_clear", 32'(error), 0);
    check("busy_fall", 32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    cyc();
    cyc();
    check("rst_ppd", 32'(ppd), 0);
    check("rst_gw", 32'(get_winner), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_id", 32'(result_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_step", 32'(step_count), 0);
    check("rst_error", 32'(error), 0);
    rst = 1'b0;
    cyc();

    // nominal run
    run_steps(1'b1);
    spike_done = 1'b0;
    cyc();
    check("gw_single", 32'(get_winner), 0);
    give_result(5'd13);
    expect_result(2);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("valid_hold", 32'(result_valid), 1);
    end
    ack_result();

    // late spike_done, extra steps and start while busy
    run_steps(1'b0);
    for (int k = 0; k < 3; k++) begin
      csf   = 1'b1;
      start = (k == 1);
      cyc();
      csf   = 1'b0;
      start = 1'b0;
      check("step_saturate", 32'(step_count), NSTEP);
      check("no_kick_run", 32'(ppd), 0);
      check("gw_early", 32'(get_winner), 0);
    end
    for (int k = 0; k < 4; k++) cyc();
    spike_done = 1'b1;
    cyc();
    spike_done = 1'b0;
    check("gw_late", 32'(get_winner), 1);
    cyc();
    give_result(5'd7);
    expect_result(2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("no_kick_hold", 32'(ppd), 0);
    check("hold_valid", 32'(result_valid), 1);
    check("hold_step", 32'(step_count), NSTEP);
    ack_result();
    cyc();
    check("no_late_kick", 32'(ppd), 0);

    // held result with toggling winner_id, then ack+start together
    run_steps(1'b1);
    spike_done = 1'b0;
    cyc();
    give_result(5'd21);
    expect_result(2);
    for (int k = 0; k < 20; k++) begin
      winner_id = 5'(k) ^ 5'h0A;
      cyc();
      check("held_id", 32'(result_id), 21);
      check("held_valid", 32'(result_valid), 1);
    end
    result_ack = 1'b1;
    start      = 1'b1;
    cyc();
    result_ack = 1'b0;
    start      = 1'b0;
    check("ackstart_valid", 32'(result_valid), 0);
    check("ackstart_busy", 32'(busy), 0);
    check("ackstart_ppd", 32'(ppd), 0);
    cyc();
    check("ackstart_no_kick", 32'(ppd), 0);
    check("ackstart_idle", 32'(busy), 0);

    // reset while waiting for the winner
    run_steps(1'b1);
    spike_done = 1'b0;
    cyc();
    check("wait_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_valid", 32'(result_valid), 0);
    check("arst_step", 32'(step_count), 0);
    check("arst_gw", 32'(get_winner), 0);
    cyc();
    rst = 1'b0;
    winner_id   = 5'd9;
    infer_ready = 1'b1;
    cyc();
    infer_ready = 1'b0;
    check("post_rst_valid", 32'(result_valid), 0);
    check("post_rst_busy", 32'(busy), 0);
    cyc();
    run_steps(1'b1);
    spike_done = 1'b0;
    cyc();
    give_result(5'd3);
    expect_result(2);
    ack_result();

    // withheld infer_ready
    run_steps(1'b1);
    spike_done = 1'b0;
`ifdef INFERENCE_SEQUENCER_TIMEOUT_EN
    exp_q.push_back(5'h1F);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check("wd_not_yet", 32'(result_valid), 0);
    end
    cyc();
    expect_result(0);
    check("wd_error", 32'(error), 1);
    check("wd_busy", 32'(busy), 1);
    ack_result();
`else
    for (int k = 0; k < 20; k++) begin
      cyc();
      check("wait_forever", 32'(result_valid), 0);
      check("error_tied", 32'(error), 0);
    end
    give_result(5'd30);
    expect_result(2);
    ack_result();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
